// File: rtl/bram_frame_writer_pkg.sv
// Shared definitions for the frame BRAM sequencer: state encodings, frame geometry
// defaults and RGB332 packing/dither helpers.
package bram_frame_writer_pkg;

  typedef enum logic [1:0] {
    BRAM_IDLE     = 2'b00,
    CAPTURE_FRAME = 2'b01,
    WRITING_FRAME = 2'b10,
    READING_FRAME = 2'b11
  } bram_state_e;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int V_ACTIVE_DEF  = 400;
  localparam int FRAME_PIX_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF;
  localparam int ADDR_W_DEF    = 18;

  // RGB332 word layout: {R[7:5], G[7:5], B[7:6]}
  localparam int R_BITS = 3;
  localparam int G_BITS = 3;
  localparam int B_BITS = 2;

  function automatic logic [7:0] pack_rgb332(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // 2x2 ordered-dither offsets indexed by {vcount[0], hcount[0]}
  function automatic logic [7:0] dith_off_rg(input logic [1:0] idx);
    case (idx)
      2'b00:   return 8'd0;
      2'b01:   return 8'd16;
      2'b10:   return 8'd24;
      2'b11:   return 8'd8;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] dith_off_b(input logic [1:0] idx);
    case (idx)
      2'b00:   return 8'd0;
      2'b01:   return 8'd32;
      2'b10:   return 8'd48;
      2'b11:   return 8'd16;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/bram_frame_writer_rgb332_quant.sv
// Registered RGB888 -> RGB332 quantizer. Optional ordered dither enabled by
// defining DITHER_EN; without it the top bits are simply truncated.
module rgb332_quant
  import bram_frame_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] pixel_in,
  input  logic [1:0]  dith_idx,
  output logic [7:0]  rgb332
);

  logic [7:0] r_s;
  logic [7:0] g_s;
  logic [7:0] b_s;

`ifdef DITHER_EN
  // Dither offset added per channel, saturating so bright pixels never wrap to dark
  always_comb begin
    r_s = sat_add8(pixel_in[23:16], dith_off_rg(dith_idx));
    g_s = sat_add8(pixel_in[15:8],  dith_off_rg(dith_idx));
    b_s = sat_add8(pixel_in[7:0],   dith_off_b(dith_idx));
  end
`else
  logic unused_dith_s;
  assign unused_dith_s = ^dith_idx;

  // Plain truncation path
  always_comb begin
    r_s = pixel_in[23:16];
    g_s = pixel_in[15:8];
    b_s = pixel_in[7:0];
  end
`endif

  // Single pipeline stage keeps the word aligned with the registered address/enable
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb332 <= 8'h00;
    end else begin
      rgb332 <= pack_rgb332(r_s, g_s, b_s);
    end
  end

endmodule

// File: rtl/bram_frame_writer.sv
// Captures one displayed frame into the frame BRAM as RGB332 and then replays it by
// address generation. Build option: DITHER_EN enables ordered dither in the quantizer.
module bram_frame_writer
  import bram_frame_writer_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int FRAME_PIX = H_ACTIVE * V_ACTIVE,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_req,
  input  logic              release_req,
  input  logic [23:0]       pixel_in,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              in_display,
  input  logic              vsync,
  output logic [1:0]        bram_state,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic              bram_we,
  output logic              frame_done,
  output logic              frame_short
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  bram_state_e       state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              vsync_r;
  logic              frame_edge_s;
  logic              at_last_s;
  logic [ADDR_W-1:0] cnt_inc_s;
  logic              unused_s;

  assign frame_edge_s = vsync_r & ~vsync;
  assign at_last_s    = (cnt_r == LAST_ADDR);
  // Counter saturates at the last frame address instead of wrapping
  assign cnt_inc_s    = at_last_s ? cnt_r : (cnt_r + ONE);
  assign bram_state   = state_r;
  assign unused_s     = ^{hcount[10:1], vcount[9:1]};

  rgb332_quant u_quant (
    .clk      (clk),
    .reset    (reset),
    .pixel_in (pixel_in),
    .dith_idx ({vcount[0], hcount[0]}),
    .rgb332   (bram_din)
  );

  // Capture/write/replay sequencer with registered BRAM port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= BRAM_IDLE;
      cnt_r       <= '0;
      vsync_r     <= 1'b1;
      bram_addr   <= '0;
      bram_we     <= 1'b0;
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
    end else begin
      vsync_r    <= vsync;
      bram_we    <= 1'b0;
      frame_done <= 1'b0;
      case (state_r)
        BRAM_IDLE: begin
          bram_addr <= '0;
          if (capture_req) state_r <= CAPTURE_FRAME;
        end
        CAPTURE_FRAME: begin
          bram_addr <= '0;
          if (frame_edge_s) begin
            cnt_r   <= '0;
            state_r <= WRITING_FRAME;
          end
        end
        WRITING_FRAME: begin
          // The final write beats a coincident frame edge
          if (in_display && at_last_s) begin
            bram_we    <= 1'b1;
            bram_addr  <= cnt_r;
            frame_done <= 1'b1;
            state_r    <= READING_FRAME;
          end else if (frame_edge_s) begin
            frame_short <= 1'b1;
            cnt_r       <= '0;
            state_r     <= CAPTURE_FRAME;
          end else if (in_display) begin
            bram_we   <= 1'b1;
            bram_addr <= cnt_r;
            cnt_r     <= cnt_inc_s;
          end
        end
        READING_FRAME: begin
          if (release_req) begin
            bram_addr <= '0;
            state_r   <= BRAM_IDLE;
          end else begin
            if (in_display) bram_addr <= cnt_r;
            if (frame_edge_s) begin
              cnt_r <= '0;
            end else if (in_display) begin
              cnt_r <= cnt_inc_s;
            end
          end
        end
        default: begin
          bram_addr <= '0;
          state_r   <= BRAM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_frame_writer.sv
// Randomized self-checking bench for bram_frame_writer on a reduced 16x8 frame.
module tb_bram_frame_writer;

  localparam int H   = 16;
  localparam int V   = 8;
  localparam int FP  = H * V;
  localparam int AW  = 18;
  localparam int HBL = 4;
  localparam int VBL = 2;
  localparam int LINE = H + HBL;
`ifdef DITHER_EN
  localparam bit DITH = 1'b1;
`else
  localparam bit DITH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, capture_req, release_req, in_display, vsync;
  logic [23:0]   pixel_in;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic [1:0]    bram_state;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_din;
  logic          bram_we, frame_done, frame_short;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  bram_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_PIX(FP), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .capture_req(capture_req), .release_req(release_req),
    .pixel_in(pixel_in), .hcount(hcount), .vcount(vcount), .in_display(in_display),
    .vsync(vsync), .bram_state(bram_state), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_we(bram_we), .frame_done(frame_done), .frame_short(frame_short)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // RGB332 from plain arithmetic: keep 3/3/2 most significant bits after optional dither
  function automatic logic [7:0] q332(input logic [23:0] px, input logic hb, input logic vb);
    int r, g, b, off, idx;
    idx = int'({vb, hb});
    off = (idx == 0) ? 0 : (idx == 1) ? 16 : (idx == 2) ? 24 : 8;
    off = DITH ? off : 0;
    r = int'(px[23:16]) + off;     if (r > 255) r = 255;
    g = int'(px[15:8]) + off;      if (g > 255) g = 255;
    b = int'(px[7:0]) + 2 * off;   if (b > 255) b = 255;
    return 8'((r / 32) * 32 + (g / 32) * 4 + b / 64);
  endfunction

  // Reference model: mode 0 idle, 1 armed, 2 storing, 3 replaying
  int            m_mode = 0;
  int            m_idx = 0;
  bit            m_prev_vs = 1'b1;
  bit            m_short = 1'b0;
  bit            m_live = 1'b0;
  logic [1:0]    e_state;
  logic          e_we, e_done, e_short, e_addr_chk, e_din_chk;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_din;

  always @(posedge clk) begin
    bit fe;
    fe = m_prev_vs && !vsync;
    e_we = 1'b0; e_done = 1'b0; e_addr_chk = 1'b0; e_addr = '0;
    e_din = q332(pixel_in, hcount[0], vcount[0]);
    if (reset) begin
      m_mode = 0; m_idx = 0; m_prev_vs = 1'b1; m_short = 1'b0;
      e_addr_chk = 1'b1; e_din = 8'h00;
    end else begin
      m_prev_vs = vsync;
      if (m_mode == 0) begin
        e_addr_chk = 1'b1;
        if (capture_req) m_mode = 1;
      end else if (m_mode == 1) begin
        e_addr_chk = 1'b1;
        if (fe) begin m_idx = 0; m_mode = 2; end
      end else if (m_mode == 2) begin
        if (in_display && m_idx == FP - 1) begin
          e_we = 1'b1; e_addr = AW'(m_idx); e_addr_chk = 1'b1; e_done = 1'b1; m_mode = 3;
        end else if (fe) begin
          m_short = 1'b1; m_idx = 0; m_mode = 1;
        end else if (in_display) begin
          e_we = 1'b1; e_addr = AW'(m_idx); e_addr_chk = 1'b1; m_idx = m_idx + 1;
        end
      end else begin
        if (release_req) begin
          m_mode = 0; e_addr_chk = 1'b1;
        end else begin
          if (in_display) begin e_addr = AW'(m_idx); e_addr_chk = 1'b1; end
          if (fe) m_idx = 0;
          else if (in_display && m_idx < FP - 1) m_idx = m_idx + 1;
        end
      end
    end
    e_din_chk = e_we || reset;
    e_state = 2'(m_mode);
    e_short = m_short;
    m_live = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("state", 32'(bram_state), 32'(e_state));
      chk("we", 32'(bram_we), 32'(e_we));
      chk("done", 32'(frame_done), 32'(e_done));
      chk("short", 32'(frame_short), 32'(e_short));
      if (e_addr_chk) chk("addr", 32'(bram_addr), 32'(e_addr));
      if (e_din_chk) chk("din", 32'(bram_din), 32'(e_din));
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  // One video frame: act active lines, then VBL blank lines with vsync low on the first
  task automatic run_frame(input int act, input bit cpx, input bit vs_last,
                           input int cap_at, input int rel_at, input int rst_at);
    for (int v = 0; v < act + VBL; v++) begin
      for (int h = 0; h < LINE; h++) begin
        int n;
        n = v * LINE + h;
        hcount = 11'(h);
        vcount = 10'(v);
        in_display = (v < act) && (h < H);
        pixel_in = cpx ? 24'hFF8040 : 24'($urandom);
        vsync = !((v == act) || (vs_last && v == act - 1 && h >= H - 1));
        capture_req = (n == cap_at);
        release_req = (n == rel_at);
        reset = (n == rst_at);
        @(posedge clk);
        #1;
        if (n == rst_at) begin
          chk("rst_mid_we", 32'(bram_we), 32'd0);
          chk("rst_mid_addr", 32'(bram_addr), 32'd0);
          chk("rst_mid_state", 32'(bram_state), 32'd0);
        end
      end
    end
    capture_req = 1'b0;
    release_req = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; capture_req = 1'b0; release_req = 1'b0; in_display = 1'b0;
    vsync = 1'b1; pixel_in = 24'h0; hcount = 11'd0; vcount = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_state", 32'(bram_state), 32'd0);
    chk("reset_we", 32'(bram_we), 32'd0);
    chk("reset_addr", 32'(bram_addr), 32'd0);
    chk("reset_din", 32'(bram_din), 32'd0);
    chk("reset_flags", 32'({frame_done, frame_short}), 32'd0);
    chk("model_ff8040", 32'(q332(24'hFF8040, 1'b0, 1'b0)), DITH ? 32'hF1 : 32'hF1);
    chk("model_707070", 32'(q332(24'h707070, 1'b1, 1'b0)), DITH ? 32'h92 : 32'h6D);

    // Arm, then capture a constant frame; stray capture/release while storing are ignored
    run_frame(V, 1'b1, 1'b0, 5, -1, -1);
    run_frame(V, 1'b1, 1'b0, 30, 50, -1);
    chk("first_done_count", 32'(done_cnt), 32'd1);
    chk("first_state", 32'(bram_state), 32'd3);
    chk("const_din", 32'(bram_din), DITH ? 32'(q332(24'hFF8040, 1'b1, 1'b1)) : 32'hF1);

    // Replay, an overlong frame to exercise saturation, then release in blanking
    run_frame(V, 1'b0, 1'b0, -1, -1, -1);
    run_frame(V + 1, 1'b0, 1'b0, -1, -1, -1);
    run_frame(V, 1'b0, 1'b0, -1, V * LINE + 5, -1);
    chk("released_state", 32'(bram_state), 32'd0);

    // Short frame then automatic retry
    run_frame(V, 1'b0, 1'b0, 3, -1, -1);
    run_frame(3, 1'b0, 1'b0, -1, -1, -1);
    chk("short_flag", 32'(frame_short), 32'd1);
    chk("short_state", 32'(bram_state), 32'd1);
    run_frame(V, 1'b0, 1'b0, -1, -1, -1);
    run_frame(V, 1'b0, 1'b0, -1, -1, -1);
    chk("retry_done_count", 32'(done_cnt), 32'd2);

    // Release, re-arm, reset in the middle of storing
    run_frame(V, 1'b0, 1'b0, -1, V * LINE + 2, -1);
    run_frame(V, 1'b0, 1'b0, 2, -1, -1);
    run_frame(V, 1'b0, 1'b0, -1, -1, 3 * LINE + 7);
    chk("rst_no_done", 32'(done_cnt), 32'd2);

    // Final write coincident with the frame edge: completion wins, no short flag
    run_frame(V, 1'b0, 1'b0, 1, -1, -1);
    run_frame(V, 1'b0, 1'b1, -1, -1, -1);
    chk("edge_last_done", 32'(done_cnt), 32'd3);
    chk("edge_last_short", 32'(frame_short), 32'd0);
    chk("edge_last_state", 32'(bram_state), 32'd3);

    // Randomized control timing
    for (int k = 0; k < 6; k++) begin
      int cap, rel;
      cap = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, (V + VBL) * LINE - 1)) : -1;
      rel = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, (V + VBL) * LINE - 1)) : -1;
      run_frame(V, 1'b0, 1'($urandom_range(0, 1)), cap, rel, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
